// File: rtl/frame_render_scheduler.sv
// Frame sequencer: clears the framebuffer, then fetches each triangle's three vertices,
// launches the rasterizer and forwards its clipped pixel stream to the framebuffer.
module frame_render_scheduler #(
  parameter int                 COORD_WIDTH  = 32,
  parameter int                 FB_WIDTH     = 320,
  parameter int                 FB_HEIGHT    = 180,
  parameter int                 FB_ADDR_W    = 16,
  parameter int                 COLOR_W      = 16,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR  = 16'h0000,
  parameter logic [COLOR_W-1:0] DRAW_COLOR   = 16'hFFFF,
  parameter int                 TRI_IDX_W    = 10,
  parameter int                 VMEM_LATENCY = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_start,
  input  logic [TRI_IDX_W-1:0]     num_tris,
  output logic [TRI_IDX_W+1:0]     vmem_addr,
  output logic                     vmem_rd,
  input  logic [3*COORD_WIDTH-1:0] vmem_data,
  output logic [9*COORD_WIDTH-1:0] tri_verts,
  output logic                     raster_start,
  input  logic                     raster_done,
  input  logic                     raster_valid,
  input  logic [COORD_WIDTH-1:0]   raster_x,
  input  logic [COORD_WIDTH-1:0]   raster_y,
  output logic                     fb_we,
  output logic [FB_ADDR_W-1:0]     fb_addr,
  output logic [COLOR_W-1:0]       fb_data,
  output logic [TRI_IDX_W-1:0]     tri_count,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int NUM_PIX    = FB_WIDTH * FB_HEIGHT;
  localparam int FETCH_LAST = VMEM_LATENCY + 2;
  localparam int FCNT_W     = $clog2(FETCH_LAST + 1);
  localparam int VADDR_W    = TRI_IDX_W + 2;
  localparam int VW         = 3 * COORD_WIDTH;

  localparam logic [FB_ADDR_W-1:0]          LAST_PIX = FB_ADDR_W'(NUM_PIX - 1);
  localparam logic [FB_ADDR_W-1:0]          ROW_LEN  = FB_ADDR_W'(FB_WIDTH);
  localparam logic signed [COORD_WIDTH-1:0] X_LIM    = COORD_WIDTH'(FB_WIDTH);
  localparam logic signed [COORD_WIDTH-1:0] Y_LIM    = COORD_WIDTH'(FB_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [FB_ADDR_W-1:0]          clear_cnt;
  logic [FCNT_W-1:0]             fetch_cnt;
  logic [VADDR_W-1:0]            vbase;
  logic [TRI_IDX_W-1:0]          num_tris_q;
  logic                          px_we;
  logic [FB_ADDR_W-1:0]          px_addr;
  logic                          pix_ok;
  logic [FB_ADDR_W-1:0]          pix_addr;
  logic                          cap_en;
  logic [1:0]                    cap_slot;
  logic                          last_tri;
  logic signed [COORD_WIDTH-1:0] sx, sy;

  assign sx = raster_x;
  assign sy = raster_y;

  // Clip against the framebuffer using signed coordinates; only in-bounds pixels reach the multiply.
  assign pix_ok = (state == S_WAIT) && raster_valid &&
                  !sx[COORD_WIDTH-1] && (sx < X_LIM) &&
                  !sy[COORD_WIDTH-1] && (sy < Y_LIM);
  assign pix_addr = sy[FB_ADDR_W-1:0] * ROW_LEN + sx[FB_ADDR_W-1:0];

  assign last_tri = (tri_count + TRI_IDX_W'(1)) == num_tris_q;

  // Read r of the triangle returns VMEM_LATENCY fetch cycles after it was issued.
  always_comb begin
    cap_en   = 1'b0;
    cap_slot = 2'd0;
    if (state == S_FETCH && fetch_cnt >= FCNT_W'(VMEM_LATENCY)) begin
      cap_en   = 1'b1;
      cap_slot = 2'(fetch_cnt - FCNT_W'(VMEM_LATENCY));
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nx     = state;
    vmem_rd      = 1'b0;
    vmem_addr    = '0;
    raster_start = 1'b0;
    busy         = 1'b0;
    frame_done   = 1'b0;
    fb_we        = px_we;
    fb_addr      = px_addr;
    fb_data      = px_we ? DRAW_COLOR : '0;

    unique case (state)
      S_IDLE: begin
        if (frame_start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        busy    = 1'b1;
        fb_we   = 1'b1;
        fb_addr = clear_cnt;
        fb_data = CLEAR_COLOR;
        if (clear_cnt == LAST_PIX) state_nx = (num_tris_q == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (fetch_cnt < FCNT_W'(3)) begin
          vmem_rd   = 1'b1;
          vmem_addr = vbase + VADDR_W'(fetch_cnt);
        end
        if (fetch_cnt == FCNT_W'(FETCH_LAST)) state_nx = S_LAUNCH;
      end
      S_LAUNCH: begin
        busy         = 1'b1;
        raster_start = 1'b1;
        state_nx     = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (raster_done) state_nx = last_tri ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clear_cnt  <= '0;
      fetch_cnt  <= '0;
      vbase      <= '0;
      num_tris_q <= '0;
      tri_count  <= '0;
      tri_verts  <= '0;
      px_we      <= 1'b0;
      px_addr    <= '0;
    end else begin
      px_we <= pix_ok;
      if (pix_ok) px_addr <= pix_addr;

      fetch_cnt <= (state == S_FETCH) ? fetch_cnt + FCNT_W'(1) : '0;

      if (cap_en) begin
        case (cap_slot)
          2'd0:    tri_verts[0*VW +: VW] <= vmem_data;
          2'd1:    tri_verts[1*VW +: VW] <= vmem_data;
          default: tri_verts[2*VW +: VW] <= vmem_data;
        endcase
      end

      if (state == S_IDLE && frame_start) begin
        num_tris_q <= num_tris;
        tri_count  <= '0;
        vbase      <= '0;
        clear_cnt  <= '0;
      end

      if (state == S_CLEAR) clear_cnt <= clear_cnt + FB_ADDR_W'(1);

      // The triangle index and the completed count advance together; vbase tracks idx*3.
      if (state == S_WAIT && raster_done) begin
        tri_count <= tri_count + TRI_IDX_W'(1);
        vbase     <= vbase + VADDR_W'(3);
      end
    end
  end

endmodule

// File: tb/tb_frame_render_scheduler.sv
// Bench for frame_render_scheduler: a scoreboard of expected BRAM reads, framebuffer writes
// and launches, driven by directed frames and pixel streams on a reduced 32x20 framebuffer.
module tb_frame_render_scheduler;

  localparam int          CW   = 32;
  localparam int          FBW  = 32;
  localparam int          FBH  = 20;
  localparam int          NPIX = FBW * FBH;
  localparam int          TIW  = 10;
  localparam logic [15:0] CLR  = 16'h0000;
  localparam logic [15:0] DRW  = 16'hFFFF;
  localparam logic [95:0] JUNK = 96'hBAD0_0000_BAD0_0000_BAD0_0000;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic            frame_start = 1'b0;
  logic [TIW-1:0]  num_tris = '0;
  logic [TIW+1:0]  vmem_addr;
  logic            vmem_rd;
  logic [3*CW-1:0] vmem_data;
  logic [9*CW-1:0] tri_verts;
  logic            raster_start;
  logic            raster_done = 1'b0;
  logic            raster_valid = 1'b0;
  logic [CW-1:0]   raster_x = '0;
  logic [CW-1:0]   raster_y = '0;
  logic            fb_we;
  logic [15:0]     fb_addr;
  logic [15:0]     fb_data;
  logic [TIW-1:0]  tri_count;
  logic            busy;
  logic            frame_done;

  frame_render_scheduler #(
    .FB_WIDTH (FBW),
    .FB_HEIGHT(FBH)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .frame_start (frame_start),
    .num_tris    (num_tris),
    .vmem_addr   (vmem_addr),
    .vmem_rd     (vmem_rd),
    .vmem_data   (vmem_data),
    .tri_verts   (tri_verts),
    .raster_start(raster_start),
    .raster_done (raster_done),
    .raster_valid(raster_valid),
    .raster_x    (raster_x),
    .raster_y    (raster_y),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .tri_count   (tri_count),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Vertex BRAM contents: a distinct word per address.
  function automatic logic [95:0] vword(input int a);
    logic [31:0] x, y, z;
    x = 32'h1000_0000 + 32'(a * 13);
    y = 32'hF000_0000 - 32'(a * 7);
    z = 32'h0003_0000 + 32'(a);
    return {z, y, x};
  endfunction

  function automatic logic [287:0] verts_of(input int t);
    return {vword(3 * t + 2), vword(3 * t + 1), vword(3 * t)};
  endfunction

  logic [95:0] vm_d1 = JUNK;
  logic [95:0] vm_d2 = JUNK;
  always @(posedge clk_in) begin
    vm_d1 <= vmem_rd ? vword(int'(vmem_addr)) : JUNK;
    vm_d2 <= vm_d1;
  end
  assign vmem_data = vm_d2;

  // Scoreboard state
  wr_t         exp_w[$];
  int          exp_r[$];
  logic [15:0] draws[$];
  int          exp_launch = 0;
  int          exp_tris   = 0;
  int          n_launch   = 0;
  int          n_rd       = 0;
  int          n_done     = 0;
  int          cyc        = 0;
  int          last_we_cyc = 0;
  int          done_cyc   = 0;

  wr_t cur_w;
  int  cur_r;

  always @(negedge clk_in) begin
    cyc++;
    if (!rst_in) begin
      if (fb_we) begin
        last_we_cyc = cyc;
        if (fb_data == DRW) draws.push_back(fb_addr);
        if (exp_w.size() == 0) check("unexpected fb_we", 288'(fb_we), 288'(0));
        else begin
          cur_w = exp_w.pop_front();
          check("fb_addr", 288'(fb_addr), 288'(cur_w.addr));
          check("fb_data", 288'(fb_data), 288'(cur_w.data));
        end
      end
      if (vmem_rd) begin
        n_rd++;
        if (exp_r.size() == 0) check("unexpected vmem_rd", 288'(vmem_rd), 288'(0));
        else begin
          cur_r = exp_r.pop_front();
          check("vmem_addr", 288'(vmem_addr), 288'(cur_r));
        end
      end
      if (raster_start) begin
        if (n_launch >= exp_launch) check("unexpected raster_start", 288'(raster_start), 288'(0));
        else check("tri_verts at launch", tri_verts, verts_of(n_launch));
        n_launch++;
      end
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
        check("tri_count at frame_done", 288'(tri_count), 288'(exp_tris));
        check("writes outstanding at frame_done", 288'(exp_w.size()), 288'(0));
        check("reads outstanding at frame_done", 288'(exp_r.size()), 288'(0));
        check("launches at frame_done", 288'(n_launch), 288'(exp_launch));
        check("busy low at frame_done", 288'(busy), 288'(0));
      end
    end
  end

  task automatic start_frame(input int n);
    exp_w.delete();
    exp_r.delete();
    draws.delete();
    for (int a = 0; a < NPIX; a++) exp_w.push_back('{16'(a), CLR});
    for (int a = 0; a < 3 * n; a++) exp_r.push_back(a);
    exp_launch = n;
    exp_tris   = n;
    n_launch   = 0;
    n_rd       = 0;
    n_done     = 0;
    @(posedge clk_in); #1;
    frame_start = 1'b1;
    num_tris    = TIW'(n);
    @(posedge clk_in); #1;
    frame_start = 1'b0;
  endtask

  task automatic px(input int x, input int y, input bit done, input bit valid);
    raster_valid = valid;
    raster_done  = done;
    raster_x     = x;
    raster_y     = y;
    if (valid && x >= 0 && x < FBW && y >= 0 && y < FBH)
      exp_w.push_back('{16'(y * FBW + x), DRW});
    @(posedge clk_in); #1;
    raster_valid = 1'b0;
    raster_done  = 1'b0;
  endtask

  task automatic wait_launch(input int k, input int budget);
    for (int i = 0; i < budget && n_launch < k; i++) begin
      @(negedge clk_in); #1;
    end
    check("raster_start reached", 288'(n_launch >= k), 288'(1));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) begin
      @(negedge clk_in); #1;
    end
    check("frame_done reached", 288'(n_done > 0), 288'(1));
  endtask

  int exp_draw[4] = '{170, 639, 67, 0};

  initial begin
    bit found;

    // Reset values
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset fb_we", 288'(fb_we), 288'(0));
    check("reset vmem_rd", 288'(vmem_rd), 288'(0));
    check("reset raster_start", 288'(raster_start), 288'(0));
    check("reset busy", 288'(busy), 288'(0));
    check("reset frame_done", 288'(frame_done), 288'(0));
    check("reset tri_count", 288'(tri_count), 288'(0));
    check("reset fb_addr", 288'(fb_addr), 288'(0));
    check("reset fb_data", 288'(fb_data), 288'(0));
    check("reset vmem_addr", 288'(vmem_addr), 288'(0));
    check("reset tri_verts", tri_verts, 288'(0));
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Reset in the middle of a clear sweep
    start_frame(0);
    @(negedge clk_in); #1;
    check("busy in CLEAR", 288'(busy), 288'(1));
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (fb_we && fb_addr == 16'd100) found = 1'b1;
      else begin
        @(negedge clk_in); #1;
      end
    end
    check("clear reached fb_addr 100", 288'(found), 288'(1));
    rst_in = 1'b1;
    exp_w.delete();
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("fb_we after mid-clear reset", 288'(fb_we), 288'(0));
    check("busy after mid-clear reset", 288'(busy), 288'(0));
    repeat (5) @(posedge clk_in);
    #1;

    // Empty triangle list: clear sweep only, restarting at address 0
    start_frame(0);
    wait_done(NPIX + 50);
    check("frame_done one cycle after last clear write", 288'(done_cyc - last_we_cyc), 288'(1));
    check("vmem_rd count, empty list", 288'(n_rd), 288'(0));
    check("raster_start count, empty list", 288'(n_launch), 288'(0));
    @(negedge clk_in);
    check("frame_done single pulse", 288'(frame_done), 288'(0));

    // Two triangles, pixel clipping, ignored frame_start and num_tris change mid-frame
    start_frame(2);
    num_tris = TIW'(5);
    wait_launch(1, NPIX + 100);
    @(posedge clk_in); #1;
    frame_start = 1'b1;
    px(10, 5, 0, 1);
    frame_start = 1'b0;
    check("busy in WAIT", 288'(busy), 288'(1));
    px(-1, 3, 0, 1);
    px(FBW, 0, 0, 1);
    px(FBW - 1, FBH - 1, 0, 1);
    px(0, FBH, 0, 1);
    px(5, -1, 0, 1);
    px(0, 0, 1, 0);
    wait_launch(2, 100);
    @(posedge clk_in); #1;
    px(3, 2, 0, 1);
    px(0, 0, 1, 1);
    wait_done(50);
    repeat (20) @(negedge clk_in);
    check("frame_done pulses in frame", 288'(n_done), 288'(1));
    check("busy after frame", 288'(busy), 288'(0));
    check("vmem_rd count, two triangles", 288'(n_rd), 288'(6));
    check("raster_start count, two triangles", 288'(n_launch), 288'(2));
    check("tri_verts held after frame", tri_verts, verts_of(1));
    check("draw write count", 288'(draws.size()), 288'(4));
    for (int i = 0; i < 4; i++)
      check($sformatf("draw[%0d] addr", i),
            288'((i < draws.size()) ? int'(draws[i]) : -1), 288'(exp_draw[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
